// File: rtl/taillight_sequencer.sv
// ---------------------------------------------------------------------------
// taillight_sequencer
//   Timing/priority controller for the rear lamp cluster. Three LEDs per side
//   ([0] inner .. [2] outer). It turns brake / left / right / hazard requests
//   into a sequential turn sweep, a hazard blink or steady brake light.
//
//   Optional feature: define BRAKE_FLASH_EN to compile in the brake flash
//   burst. A brake 0->1 edge in IDLE gives 6 tick periods of alternating
//   111/000, starting lit, then steady 111. Without the macro, brake is
//   steady 111 at once.
//
// Parameters
//   TICK_DIV      clk cycles per animation step (>= 2)
// Ports
//   i_clk         system clock, all logic on posedge
//   i_rst         synchronous reset, active-high
//   i_brake       brake pedal request, level
//   i_turn_left   left indicator request, level
//   i_turn_right  right indicator request, level
//   i_hazard      hazard switch, level
//   o_led_l[2:0]  left lamp drive, 1 = lit (registered)
//   o_led_r[2:0]  right lamp drive, 1 = lit (registered)
// ---------------------------------------------------------------------------
module taillight_sequencer #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_brake,
    input  logic       i_turn_left,
    input  logic       i_turn_right,
    input  logic       i_hazard,
    output logic [2:0] o_led_l,
    output logic [2:0] o_led_r
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} mode_t;

    mode_t         r_mode;
    mode_t         w_mode;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_phase;
    logic [1:0]    w_phase_nxt;
    logic          w_tick;
    logic [2:0]    w_sweep;
    logic [2:0]    w_led_l_nxt;
    logic [2:0]    w_led_r_nxt;
`ifdef BRAKE_FLASH_EN
    logic          r_brake_d;
    logic [2:0]    r_burst;
    logic [2:0]    w_burst_nxt;
    logic          w_brake_rise;
`endif

    // State register. Outputs are registered from the next-state view so that
    // an input change is visible on the lamps exactly one clk later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode    <= IDLE;
            r_cnt     <= '0;
            r_phase   <= 2'd0;
            o_led_l   <= 3'b000;
            o_led_r   <= 3'b000;
`ifdef BRAKE_FLASH_EN
            r_brake_d <= 1'b0;
            r_burst   <= 3'd0;
`endif
        end else begin
            r_mode    <= w_mode;
            r_cnt     <= w_cnt_nxt;
            r_phase   <= w_phase_nxt;
            o_led_l   <= w_led_l_nxt;
            o_led_r   <= w_led_r_nxt;
`ifdef BRAKE_FLASH_EN
            r_brake_d <= i_brake;
            r_burst   <= w_burst_nxt;
`endif
        end
    end

    // Next-state: mode priority, tick counter and phase.
    always_comb begin
        w_mode = IDLE;
        if (i_hazard || (i_turn_left && i_turn_right))
            w_mode = HAZARD;
        else if (i_turn_left)
            w_mode = LEFT;
        else if (i_turn_right)
            w_mode = RIGHT;

        w_tick = (r_cnt == CW'(TICK_DIV - 1));

        // Any mode change (including back to IDLE) restarts the pattern.
        if (w_mode != r_mode) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = 2'd0;
        end else begin
            w_cnt_nxt   = w_tick ? '0 : r_cnt + CW'(1);
            w_phase_nxt = r_phase + 2'(w_tick);
        end

`ifdef BRAKE_FLASH_EN
        // Burst counter holds 6..0; it counts down one per tick. Odd values
        // are the dark half-periods. Releasing brake or leaving IDLE kills it.
        w_brake_rise = i_brake && !r_brake_d && (w_mode == IDLE);
        w_burst_nxt  = r_burst;
        if (w_brake_rise) begin
            w_burst_nxt = 3'd6;
            w_cnt_nxt   = '0;
        end else if (!i_brake || (w_mode != IDLE)) begin
            w_burst_nxt = 3'd0;
        end else if (w_tick && (r_burst != 3'd0)) begin
            w_burst_nxt = r_burst - 3'd1;
        end
`endif
    end

    // Output decode from the next mode/phase.
    always_comb begin
        case (w_phase_nxt)
            2'd1:    w_sweep = 3'b001;
            2'd2:    w_sweep = 3'b011;
            2'd3:    w_sweep = 3'b111;
            default: w_sweep = 3'b000;
        endcase

        w_led_l_nxt = {3{i_brake}};
        w_led_r_nxt = {3{i_brake}};
        case (w_mode)
            LEFT:    w_led_l_nxt = w_sweep;
            RIGHT:   w_led_r_nxt = w_sweep;
            HAZARD: begin
                // Brake is ignored here; dark phases stay dark.
                w_led_l_nxt = {3{w_phase_nxt[0]}};
                w_led_r_nxt = {3{w_phase_nxt[0]}};
            end
            default: ;
        endcase

`ifdef BRAKE_FLASH_EN
        // Non-zero burst only exists in IDLE with brake held.
        if (w_burst_nxt != 3'd0) begin
            w_led_l_nxt = {3{~w_burst_nxt[0]}};
            w_led_r_nxt = {3{~w_burst_nxt[0]}};
        end
`endif
    end

endmodule

// File: tb/tb_taillight_sequencer.sv
// ---------------------------------------------------------------------------
// tb_taillight_sequencer
//   Directed scenarios plus held-random stimulus for taillight_sequencer with
//   TICK_DIV=4. A behavioural model computes the lamp value due after each
//   edge from the inputs driven for it. That value goes into a queue, and the
//   queue is popped once the DUT output has settled after the edge.
// ---------------------------------------------------------------------------
module tb_taillight_sequencer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst, brake, tl, tr, hz;
    logic [2:0] led_l, led_r;

    int n_chk = 0;
    int n_bad = 0;

    logic [5:0] sb_q[$];

    // model state: cycles since the current mode began, burst age (-1 = none)
    int m_mode = 0;
    int m_el   = 0;
    int m_bel  = -1;
    bit m_bprev = 1'b0;

    taillight_sequencer #(.TICK_DIV(TD)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_brake      (brake),
        .i_turn_left  (tl),
        .i_turn_right (tr),
        .i_hazard     (hz),
        .o_led_l      (led_l),
        .o_led_r      (led_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got l=%b r=%b want l=%b r=%b",
                     tag, $time, got[5:3], got[2:0], exp[5:3], exp[2:0]);
        end
    endtask

    // Expected {led_l, led_r} after the coming edge, from the driven inputs.
    task automatic model_step(output logic [5:0] e);
        int md, ph;
        logic [2:0] all1, sw, l, r;
        if (rst) begin
            m_mode = 0; m_el = 0; m_bel = -1; m_bprev = 1'b0;
            e = 6'b0;
            return;
        end
        md = (hz || (tl && tr)) ? 3 : tl ? 1 : tr ? 2 : 0;
        if (md != m_mode) m_el = 0;
        else              m_el++;
        m_mode = md;
        ph   = (m_el / TD) % 4;
        all1 = 3'b111;
        sw   = all1 >> (3 - ph);
        l = {3{brake}};
        r = {3{brake}};
        if (md == 1) l = sw;
        if (md == 2) r = sw;
        if (md == 3) begin
            l = (ph % 2 == 1) ? 3'b111 : 3'b000;
            r = l;
        end
`ifdef BRAKE_FLASH_EN
        if (brake && !m_bprev && md == 0)       m_bel = 0;
        else if (m_bel >= 0 && (!brake || md != 0)) m_bel = -1;
        else if (m_bel >= 0)                    m_bel++;
        if (m_bel >= 6 * TD) m_bel = -1;
        if (m_bel >= 0) begin
            l = ((m_bel / TD) % 2 == 0) ? 3'b111 : 3'b000;
            r = l;
        end
`endif
        m_bprev = brake;
        e = {l, r};
    endtask

    task automatic cyc(input string tag, input int n);
        logic [5:0] e, exp;
        for (int i = 0; i < n; i++) begin
            model_step(e);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_empty"}, {led_l, led_r}, 6'bxxxxxx);
            end else begin
                exp = sb_q.pop_front();
                chk(tag, {led_l, led_r}, exp);
            end
        end
    endtask

    task automatic drive(input logic r, input logic b, input logic l,
                         input logic rt, input logic h);
        rst = r; brake = b; tl = l; tr = rt; hz = h;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        // 1. reset, then release with everything idle
        cyc("reset", 2);
        drive(0, 0, 0, 0, 0);
        cyc("idle", 3);
        // 2. left sweep, right side dark
        drive(0, 0, 1, 0, 0);
        cyc("left_sweep", 20);
        // 3. right sweep with brake, then drop brake mid-sweep
        drive(0, 1, 0, 1, 0);
        cyc("right_brake", 9);
        drive(0, 0, 0, 1, 0);
        cyc("right_nobrake", 7);
        // 4. hazard, then both turns (mode stays HAZARD, no restart)
        drive(0, 1, 0, 0, 1);
        cyc("hazard", 10);
        drive(0, 0, 1, 1, 0);
        cyc("both_turn", 10);
        // 5. left 6 clk, switch to right, then reset mid-sweep
        drive(0, 0, 0, 0, 0);
        cyc("idle2", 2);
        drive(0, 0, 1, 0, 0);
        cyc("left6", 6);
        drive(0, 0, 0, 1, 0);
        cyc("right_restart", 7);
        drive(1, 0, 0, 1, 0);
        cyc("rst_mid", 1);
        drive(0, 0, 0, 1, 0);
        cyc("after_rst", 5);
        // 6. brake in IDLE: full burst, then an aborted one
        drive(0, 0, 0, 0, 0);
        cyc("idle3", 3);
        drive(0, 1, 0, 0, 0);
        cyc("brake_long", 30);
        drive(0, 0, 0, 0, 0);
        cyc("brake_off", 2);
        drive(0, 1, 0, 0, 0);
        cyc("brake_short", 10);
        drive(0, 0, 0, 0, 0);
        cyc("brake_abort", 3);
        // burst aborted by a turn, brake held through return to IDLE
        drive(0, 1, 0, 0, 0);
        cyc("brake_rise2", 5);
        drive(0, 1, 1, 0, 0);
        cyc("brake_left", 6);
        drive(0, 1, 0, 0, 0);
        cyc("brake_back", 8);
        // held-random mix
        for (int k = 0; k < 60; k++) begin
            drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0));
            cyc("rand", $urandom_range(1, 12));
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
